pe_tile_sched: RTL and testbench

//  Sequencer for one DIMxDIM tile of DP-based PEs. Accepts one operand beat per cycle
//  (DIM data lanes + DIM weight lanes) over valid/ready. Skews lanes into the systolic

---
 rtl/pe_tile_sched.sv | 153 +++++++++++++++
 tb/tb_pe_tile_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_sched.sv
// Tile sequencer for a DIMxDIM systolic PE array: clear, stream
// skewed operand beats, drain the wavefront, then hand off the result.
module pe_tile_sched #(
  parameter int DIM    = 2,
  parameter int B      = 4,
  parameter int KW     = 8,
  parameter int PE_LAT = 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [KW-1:0]               k_len_i,
  input  logic                        abort_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [DIM-1:0][2*B-1:0]     in_data_i,
  input  logic [DIM-1:0][2*B-1:0]     in_wgt_i,
  output logic [DIM-1:0][2*B-1:0]     pe_data_o,
  output logic [DIM-1:0][2*B-1:0]     pe_wgt_o,
  output logic                        pe_en_o,
  output logic                        pe_clear_o,
  output logic                        busy_o,
  output logic                        res_valid_o,
  input  logic                        res_ready_i
);

  localparam int W    = 2 * B;
  localparam int DLEN = 2 * (DIM - 1) + PE_LAT;
  localparam int DW   = $clog2(DLEN + 1);
  localparam logic [DW-1:0] DLAST = DW'(DLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_RESULT
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   klen_q, klen_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [DW-1:0]   drain_q, drain_d;

  logic [DIM-1:0][W-1:0] lane_d;
  logic [DIM-1:0][W-1:0] lane_w;

  // Drain pushes zeros so the wavefront flushes without new products
  assign lane_d = (state_q == S_STREAM) ? in_data_i : '0;
  assign lane_w = (state_q == S_STREAM) ? in_wgt_i  : '0;
  assign busy_o = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    klen_d      = klen_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    in_ready_o  = 1'b0;
    pe_en_o     = 1'b0;
    pe_clear_o  = 1'b0;
    res_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          klen_d  = k_len_i;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        pe_clear_o = 1'b1;
        beat_d     = '0;
        drain_d    = '0;
        state_d    = (klen_q != '0) ? S_STREAM : S_DRAIN;
      end
      S_STREAM: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          pe_en_o = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_d == klen_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pe_en_o = 1'b1;
        if (drain_q == DLAST) begin
          drain_d = '0;
          state_d = S_RESULT;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_RESULT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d     = S_IDLE;
      beat_d      = '0;
      drain_d     = '0;
      pe_clear_o  = 1'b1;
      pe_en_o     = 1'b0;
      in_ready_o  = 1'b0;
      res_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // Lane r is delayed r enabled cycles behind the registered beat
  for (genvar r = 0; r < DIM; r++) begin : g_lane
    logic [W-1:0] dsk_q [0:r];
    logic [W-1:0] wsk_q [0:r];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        for (int j = 0; j <= r; j++) begin
          dsk_q[j] <= '0;
          wsk_q[j] <= '0;
        end
      end else if (abort_i) begin
        for (int j = 0; j <= r; j++) begin
          dsk_q[j] <= '0;
          wsk_q[j] <= '0;
        end
      end else if (pe_en_o) begin
        dsk_q[0] <= lane_d[r];
        wsk_q[0] <= lane_w[r];
        for (int j = 1; j <= r; j++) begin
          dsk_q[j] <= dsk_q[j-1];
          wsk_q[j] <= wsk_q[j-1];
        end
      end
    end

    assign pe_data_o[r] = dsk_q[r];
    assign pe_wgt_o[r]  = wsk_q[r];
  end

endmodule

// File: tb/tb_pe_tile_sched.sv
// Bench for pe_tile_sched: cycle-by-cycle expected handshakes plus a
// beat-history scoreboard for the skewed lane outputs.
module tb_pe_tile_sched;

  localparam int DIM    = 2;
  localparam int B      = 4;
  localparam int KW     = 8;
  localparam int PE_LAT = 1;
  localparam int W      = 2 * B;
  localparam int DLEN   = 2 * (DIM - 1) + PE_LAT;

  typedef struct packed {
    logic [DIM-1:0][W-1:0] d;
    logic [DIM-1:0][W-1:0] w;
  } beat_t;

  logic                  clk_i = 0;
  logic                  reset_n_i;
  logic                  start_i;
  logic [KW-1:0]         k_len_i;
  logic                  abort_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DIM-1:0][W-1:0] in_data_i;
  logic [DIM-1:0][W-1:0] in_wgt_i;
  logic [DIM-1:0][W-1:0] pe_data_o;
  logic [DIM-1:0][W-1:0] pe_wgt_o;
  logic                  pe_en_o;
  logic                  pe_clear_o;
  logic                  busy_o;
  logic                  res_valid_o;
  logic                  res_ready_i;

  int checks = 0;
  int errors = 0;
  beat_t hist[$];

  pe_tile_sched #(
    .DIM(DIM), .B(B), .KW(KW), .PE_LAT(PE_LAT)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .start_i(start_i),
    .k_len_i(k_len_i),
    .abort_i(abort_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i(in_data_i),
    .in_wgt_i(in_wgt_i),
    .pe_data_o(pe_data_o),
    .pe_wgt_o(pe_wgt_o),
    .pe_en_o(pe_en_o),
    .pe_clear_o(pe_clear_o),
    .busy_o(busy_o),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_lanes();
    beat_t e;
    for (int r = 0; r < DIM; r++) begin
      e = (hist.size() > r) ? hist[hist.size()-1-r] : '0;
      chk($sformatf("data%0d", r), 32'(pe_data_o[r]), 32'(e.d[r]));
      chk($sformatf("wgt%0d", r), 32'(pe_wgt_o[r]), 32'(e.w[r]));
    end
  endtask

  task automatic rnd_lanes();
    for (int r = 0; r < DIM; r++) begin
      in_data_i[r] = W'($urandom_range(1, 255));
      in_wgt_i[r]  = W'($urandom_range(1, 255));
    end
  endtask

  task automatic tick(input bit en, input bit rdy, input bit clr,
                      input bit bsy, input bit rv, input bit drn,
                      input bit flush);
    beat_t b;
    @(negedge clk_i);
    chk("pe_en", 32'(pe_en_o), 32'(en));
    chk("in_ready", 32'(in_ready_o), 32'(rdy));
    chk("pe_clear", 32'(pe_clear_o), 32'(clr));
    chk("busy", 32'(busy_o), 32'(bsy));
    chk("res_valid", 32'(res_valid_o), 32'(rv));
    chk_lanes();
    @(posedge clk_i);
    if (flush) begin
      hist.delete();
    end else if (en) begin
      b.d = drn ? '0 : in_data_i;
      b.w = drn ? '0 : in_wgt_i;
      hist.push_back(b);
      if (hist.size() > DIM) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic run_job(input int k, input int stall_mask,
                         input int rdy_wait, input int abort_after,
                         input bit rst_drain);
    int beats = 0;
    int s = 0;
    bit v;
    start_i = 1;
    k_len_i = KW'(k);
    tick(0, 0, 0, 0, 0, 0, 0);
    start_i = 0;
    k_len_i = '0;
    tick(0, 0, 1, 1, 0, 0, 0);
    while (beats < k) begin
      if (beats == abort_after) begin
        abort_i = 1;
        in_valid_i = 1;
        tick(0, 0, 1, 1, 0, 0, 1);
        abort_i = 0;
        in_valid_i = 0;
        tick(0, 0, 0, 0, 0, 0, 0);
        return;
      end
      v = (s < 32) ? !stall_mask[s] : 1'b1;
      in_valid_i = v;
      rnd_lanes();
      tick(v, 1, 0, 1, 0, 0, 0);
      if (v) beats++;
      s++;
    end
    for (int d = 0; d < DLEN; d++) begin
      in_valid_i = 1;
      rnd_lanes();
      tick(1, 0, 0, 1, 0, 1, 0);
      if (rst_drain && d == 0) begin
        reset_n_i = 0;
        #1;
        chk("rst_en", 32'(pe_en_o), 0);
        chk("rst_ready", 32'(in_ready_o), 0);
        chk("rst_clear", 32'(pe_clear_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_rv", 32'(res_valid_o), 0);
        chk("rst_data", 32'(pe_data_o), 0);
        chk("rst_wgt", 32'(pe_wgt_o), 0);
        hist.delete();
        #1;
        reset_n_i = 1;
        in_valid_i = 0;
        tick(0, 0, 0, 0, 0, 0, 0);
        return;
      end
    end
    in_valid_i = 0;
    for (int w = 0; w <= rdy_wait; w++) begin
      res_ready_i = (w == rdy_wait);
      start_i = (w != rdy_wait) && w[0];
      tick(0, 0, 0, 1, 1, 0, 0);
    end
    res_ready_i = 0;
    start_i = 0;
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n_i   = 0;
    start_i     = 0;
    k_len_i     = '0;
    abort_i     = 0;
    in_valid_i  = 0;
    in_data_i   = '0;
    in_wgt_i    = '0;
    res_ready_i = 0;
    #2;
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_en", 32'(pe_en_o), 0);
    chk("reset_data", 32'(pe_data_o), 0);
    @(posedge clk_i);
    #3;
    reset_n_i = 1;
    @(posedge clk_i);
    #1;

    run_job(3, 0, 0, -1, 0);
    run_job(3, 'b01010, 0, -1, 0);
    run_job(0, 0, 0, -1, 0);
    run_job(3, 0, 0, 1, 0);
    run_job(2, 0, 0, -1, 0);
    run_job(2, 0, 10, -1, 0);

    start_i = 1;
    abort_i = 1;
    k_len_i = 8'd2;
    tick(0, 0, 1, 0, 0, 0, 1);
    start_i = 0;
    abort_i = 0;
    tick(0, 0, 0, 0, 0, 0, 0);

    run_job(2, 0, 0, -1, 1);
    run_job(1, 0, 0, -1, 0);
    run_job(255, 'h5, 0, -1, 0);
    run_job(2, 0, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
